// File: rtl/hsstlp_rst_pkg.sv
// Shared definitions for the HSSTLP lane reset sequencers: state encoding,
// timing constants derived from the free-running clock frequency, counter sizing.
package hsstlp_rst_pkg;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_PWRUP     = 4'd1,
      ST_SYNC      = 4'd2,
      ST_WAIT_LOCK = 4'd3,
      ST_PCS       = 4'd4,
      ST_DONE      = 4'd5,
      ST_RATE      = 4'd6,
      ST_LRST      = 4'd7
   } rst_state_e;

   // All constants are in free-clock cycles, f is the clock frequency in MHz
   function automatic int unsigned t_pma_rel(input int unsigned f);
      return f;
   endfunction

   function automatic int unsigned t_piso_rel(input int unsigned f);
      return 2 * f;
   endfunction

   function automatic int unsigned t_drv_rel(input int unsigned f);
      return 3 * f;
   endfunction

   function automatic int unsigned t_sync_len(input int unsigned f);
      return f / 5;
   endfunction

   function automatic int unsigned t_pcs_rel(input int unsigned f);
      return f;
   endfunction

   function automatic int unsigned t_rc_on_f(input int unsigned f);
      return f / 5;
   endfunction

   function automatic int unsigned t_rc_sync_r(input int unsigned f);
      return (3 * f) / 5;
   endfunction

   function automatic int unsigned t_rc_rate(input int unsigned f);
      return (7 * f) / 10;
   endfunction

   function automatic int unsigned t_rc_sync_f(input int unsigned f);
      return (4 * f) / 5;
   endfunction

   function automatic int unsigned t_rc_pma_f(input int unsigned f);
      return (9 * f) / 10;
   endfunction

   function automatic int unsigned t_rc_on_r(input int unsigned f);
      return (13 * f) / 10;
   endfunction

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   function automatic int unsigned cntr_w(input int unsigned max_cnt);
      return $clog2(max_cnt) + 1;
   endfunction

endpackage

// File: rtl/hsstlp_txlane_rst_ctrl_mx_sync2.sv
// Two-flop synchroniser for a single asynchronous level.
module hsstlp_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/hsstlp_txlane_rst_ctrl_mx.sv
// Bonded TX lane power-up / reset / rate-change sequencer for the HSSTLP wrapper.
// One FSM drives every lane; per-lane enables only mask the outputs.
module hsstlp_txlane_rst_ctrl_mx
   import hsstlp_rst_pkg::*;
#(
   parameter int unsigned LANE_NUM        = 1,
   parameter int unsigned FREE_CLOCK_FREQ = 100,
   parameter int unsigned P_LX_TX_CKDIV   = 0,
   parameter int unsigned EXPLL_USE       = 0,
   parameter int unsigned LOCK_TIMEOUT_US = 1000,
   parameter int unsigned DONE_DLY        = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [LANE_NUM-1:0]     i_lane_en,
   input  logic                    i_txlane_rst_n,
   input  logic                    i_pll_lock,
   input  logic                    i_rate_req,
   input  logic [2:0]              i_txckdiv,
   output logic                    o_rate_ack,
   output logic [LANE_NUM-1:0]     o_tx_pd_clkpath,
   output logic [LANE_NUM-1:0]     o_tx_pd_piso,
   output logic [LANE_NUM-1:0]     o_tx_pd_driver,
   output logic [LANE_NUM-1:0]     o_tx_pma_rst,
   output logic [LANE_NUM-1:0]     o_pcs_tx_rst,
   output logic [3*LANE_NUM-1:0]   o_tx_rate,
   output logic                    o_lane_sync,
   output logic                    o_rate_change_on,
   output logic                    o_txlane_done,
   output logic                    o_lock_timeout
);

   localparam int unsigned F         = FREE_CLOCK_FREQ;
   localparam int unsigned PMA_REL   = t_pma_rel(F);
   localparam int unsigned PISO_REL  = t_piso_rel(F);
   localparam int unsigned DRV_REL   = t_drv_rel(F);
   localparam int unsigned SYNC_LEN  = t_sync_len(F);
   localparam int unsigned PCS_REL   = t_pcs_rel(F);
   localparam int unsigned RC_ON_F   = t_rc_on_f(F);
   localparam int unsigned RC_SYNC_R = t_rc_sync_r(F);
   localparam int unsigned RC_RATE   = t_rc_rate(F);
   localparam int unsigned RC_SYNC_F = t_rc_sync_f(F);
   localparam int unsigned RC_PMA_F  = t_rc_pma_f(F);
   localparam int unsigned RC_ON_R   = t_rc_on_r(F);
   localparam int unsigned TMO       = LOCK_TIMEOUT_US * F;
   localparam int unsigned CNT_MAX   = max2(max2(DRV_REL, RC_ON_R), max2(PCS_REL + DONE_DLY, TMO));
   localparam int unsigned CW        = cntr_w(CNT_MAX);

   rst_state_e    state;
   logic [CW-1:0] cnt;
   logic          pd_clk;
   logic          pd_piso;
   logic          pd_drv;
   logic          pma_rst;
   logic          pcs_rst;
   logic          lane_sync;
   logic          rc_on;
   logic          done;
   logic          rate_ack;
   logic          lock_tmo;
   logic [2:0]    rate;
   logic [2:0]    rate_cap;
   logic          lock_q;
   logic          lock_s;
   logic          lrst_go;

   hsstlp_sync2 u_lock_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (i_pll_lock),
      .q     (lock_q)
   );

   assign lock_s  = (EXPLL_USE != 0) ? lock_q : 1'b1;

   // Soft reset outranks lock loss, which outranks a rate request
   assign lrst_go = (!i_txlane_rst_n &&
                     (state inside {ST_SYNC, ST_WAIT_LOCK, ST_PCS, ST_DONE, ST_RATE})) ||
                    (state == ST_DONE && !lock_s);

   // Action at constant K fires K cycles after state entry (cnt == K-1)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         pd_clk    <= 1'b1;
         pd_piso   <= 1'b1;
         pd_drv    <= 1'b1;
         pma_rst   <= 1'b1;
         pcs_rst   <= 1'b1;
         lane_sync <= 1'b0;
         rc_on     <= 1'b1;
         done      <= 1'b0;
         rate_ack  <= 1'b0;
         lock_tmo  <= 1'b0;
         rate      <= 3'(P_LX_TX_CKDIV);
         rate_cap  <= 3'(P_LX_TX_CKDIV);
      end else begin
         rate_ack <= 1'b0;
         cnt      <= cnt + CW'(1);
         case (state)
            ST_IDLE: begin
               state <= ST_PWRUP;
               cnt   <= '0;
            end
            ST_PWRUP, ST_LRST: begin
               if (state == ST_LRST && !i_txlane_rst_n) begin
                  cnt     <= '0;
                  pd_piso <= 1'b1;
                  pd_drv  <= 1'b1;
                  pma_rst <= 1'b1;
                  pcs_rst <= 1'b1;
                  done    <= 1'b0;
               end else begin
                  if (state == ST_PWRUP && cnt == '0) pd_clk <= 1'b0;
                  if (cnt == CW'(PMA_REL - 1))  pma_rst <= 1'b0;
                  if (cnt == CW'(PISO_REL - 1)) pd_piso <= 1'b0;
                  if (cnt == CW'(DRV_REL - 1)) begin
                     pd_drv <= 1'b0;
                     cnt    <= '0;
                     if (LANE_NUM > 1) begin
                        state     <= ST_SYNC;
                        lane_sync <= 1'b1;
                     end else begin
                        state <= ST_WAIT_LOCK;
                     end
                  end
               end
            end
            ST_SYNC: begin
               if (cnt == CW'(SYNC_LEN - 1)) begin
                  lane_sync <= 1'b0;
                  state     <= ST_WAIT_LOCK;
                  cnt       <= '0;
               end
            end
            ST_WAIT_LOCK: begin
               if (lock_s) begin
                  state <= ST_PCS;
                  cnt   <= '0;
               end else begin
                  if (cnt == CW'(TMO - 1)) lock_tmo <= 1'b1;
                  if (cnt == CW'(TMO))     cnt      <= cnt;
               end
            end
            ST_PCS: begin
               if (cnt == CW'(PCS_REL - 1)) pcs_rst <= 1'b0;
               if (cnt == CW'(PCS_REL + DONE_DLY - 1)) begin
                  done  <= 1'b1;
                  state <= ST_DONE;
                  cnt   <= '0;
               end
            end
            ST_DONE: begin
               cnt <= '0;
               if (lock_s && i_rate_req) begin
                  rate_cap <= i_txckdiv;
                  state    <= ST_RATE;
                  done     <= 1'b0;
                  pcs_rst  <= 1'b1;
               end
            end
            ST_RATE: begin
               if (cnt == CW'(RC_ON_F - 1)) rc_on <= 1'b0;
               if (cnt == CW'(RC_SYNC_R - 1)) begin
                  pma_rst   <= 1'b1;
                  lane_sync <= 1'(LANE_NUM > 1);
               end
               if (cnt == CW'(RC_RATE - 1))   rate      <= rate_cap;
               if (cnt == CW'(RC_SYNC_F - 1)) lane_sync <= 1'b0;
               if (cnt == CW'(RC_PMA_F - 1))  pma_rst   <= 1'b0;
               if (cnt == CW'(RC_ON_R - 1)) begin
                  rc_on    <= 1'b1;
                  rate_ack <= 1'b1;
                  state    <= ST_PCS;
                  cnt      <= '0;
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase

         // Re-sequence without touching the clock path or the applied rate
         if (lrst_go) begin
            state     <= ST_LRST;
            cnt       <= '0;
            pd_piso   <= 1'b1;
            pd_drv    <= 1'b1;
            pma_rst   <= 1'b1;
            pcs_rst   <= 1'b1;
            done      <= 1'b0;
            lane_sync <= 1'b0;
            rc_on     <= 1'b1;
            rate_ack  <= 1'b0;
         end

         if (!i_txlane_rst_n) lock_tmo <= 1'b0;
      end
   end

   // Disabled lanes always show powered-down and in reset
   assign o_tx_pd_clkpath  = {LANE_NUM{pd_clk}}  | ~i_lane_en;
   assign o_tx_pd_piso     = {LANE_NUM{pd_piso}} | ~i_lane_en;
   assign o_tx_pd_driver   = {LANE_NUM{pd_drv}}  | ~i_lane_en;
   assign o_tx_pma_rst     = {LANE_NUM{pma_rst}} | ~i_lane_en;
   assign o_pcs_tx_rst     = {LANE_NUM{pcs_rst}} | ~i_lane_en;
   assign o_tx_rate        = {LANE_NUM{rate}};
   assign o_lane_sync      = lane_sync;
   assign o_rate_change_on = rc_on;
   assign o_txlane_done    = done;
   assign o_rate_ack       = rate_ack;
   assign o_lock_timeout   = lock_tmo;

endmodule

// File: tb/tb_hsstlp_txlane_rst_ctrl_mx.sv
// Directed bench for the bonded TX lane sequencer: power-up table, rate change,
// lock loss with timeout, soft reset during rate change, lane masking.
module tb_hsstlp_txlane_rst_ctrl_mx;

   logic       clk;
   logic       rst_n;
   logic [1:0] lane_en;
   logic       txlane_rst_n;
   logic       pll_lock;
   logic       rate_req;
   logic [2:0] txckdiv;
   logic       rate_ack;
   logic [1:0] pd_clk, pd_piso, pd_drv, pma, pcs;
   logic [5:0] tx_rate;
   logic       lane_sync, rc_on, done, tmo;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   hsstlp_txlane_rst_ctrl_mx #(
      .LANE_NUM        (2),
      .FREE_CLOCK_FREQ (100),
      .P_LX_TX_CKDIV   (1),
      .EXPLL_USE       (1),
      .LOCK_TIMEOUT_US (1),
      .DONE_DLY        (32)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_lane_en        (lane_en),
      .i_txlane_rst_n   (txlane_rst_n),
      .i_pll_lock       (pll_lock),
      .i_rate_req       (rate_req),
      .i_txckdiv        (txckdiv),
      .o_rate_ack       (rate_ack),
      .o_tx_pd_clkpath  (pd_clk),
      .o_tx_pd_piso     (pd_piso),
      .o_tx_pd_driver   (pd_drv),
      .o_tx_pma_rst     (pma),
      .o_pcs_tx_rst     (pcs),
      .o_tx_rate        (tx_rate),
      .o_lane_sync      (lane_sync),
      .o_rate_change_on (rc_on),
      .o_txlane_done    (done),
      .o_lock_timeout   (tmo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [1:0] en;
      logic [1:0] clkp, pma, piso, drv, pcs;
      logic       sync, done;
   } pv_t;

   typedef struct {
      int         off;
      logic       rc, ack, sync;
      logic [1:0] pma;
      logic [5:0] rate;
      logic       done;
      logic [1:0] pcs;
   } rv_t;

   pv_t pv [17];
   rv_t rv [16];

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   // Advance to absolute cycle c (edges since reset release), sample 1 unit after the edge
   task automatic go_to(input int c);
      while (cyc < c) begin
         @(posedge clk);
         cyc++;
      end
      #1;
   endtask

   task automatic release_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cyc   = 0;
   endtask

   int le, w, e, e2, s;

   initial begin
      rst_n = 1'b0; lane_en = 2'b11; txlane_rst_n = 1'b1; pll_lock = 1'b1;
      rate_req = 1'b0; txckdiv = 3'd0;

      //        cyc   en     clk    pma    piso   drv    pcs    sync done
      pv[0]  = '{0,   2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 0, 0};
      pv[1]  = '{1,   2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 0, 0};
      pv[2]  = '{2,   2'b11, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11, 0, 0};
      pv[3]  = '{100, 2'b11, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11, 0, 0};
      pv[4]  = '{101, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11, 0, 0};
      pv[5]  = '{150, 2'b10, 2'b01, 2'b01, 2'b11, 2'b11, 2'b11, 0, 0};
      pv[6]  = '{151, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11, 0, 0};
      pv[7]  = '{200, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11, 0, 0};
      pv[8]  = '{201, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 0, 0};
      pv[9]  = '{300, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 0, 0};
      pv[10] = '{301, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 1, 0};
      pv[11] = '{320, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 1, 0};
      pv[12] = '{321, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 0, 0};
      pv[13] = '{421, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 0, 0};
      pv[14] = '{422, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0};
      pv[15] = '{453, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0};
      pv[16] = '{454, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1};

      //        off  rc ack sync pma    rate       done pcs
      rv[0]  = '{0,   1, 0, 0, 2'b00, 6'b001001, 0, 2'b11};
      rv[1]  = '{19,  1, 0, 0, 2'b00, 6'b001001, 0, 2'b11};
      rv[2]  = '{20,  0, 0, 0, 2'b00, 6'b001001, 0, 2'b11};
      rv[3]  = '{59,  0, 0, 0, 2'b00, 6'b001001, 0, 2'b11};
      rv[4]  = '{60,  0, 0, 1, 2'b11, 6'b001001, 0, 2'b11};
      rv[5]  = '{69,  0, 0, 1, 2'b11, 6'b001001, 0, 2'b11};
      rv[6]  = '{70,  0, 0, 1, 2'b11, 6'b010010, 0, 2'b11};
      rv[7]  = '{80,  0, 0, 0, 2'b11, 6'b010010, 0, 2'b11};
      rv[8]  = '{90,  0, 0, 0, 2'b00, 6'b010010, 0, 2'b11};
      rv[9]  = '{129, 0, 0, 0, 2'b00, 6'b010010, 0, 2'b11};
      rv[10] = '{130, 1, 1, 0, 2'b00, 6'b010010, 0, 2'b11};
      rv[11] = '{131, 1, 0, 0, 2'b00, 6'b010010, 0, 2'b11};
      rv[12] = '{229, 1, 0, 0, 2'b00, 6'b010010, 0, 2'b11};
      rv[13] = '{230, 1, 0, 0, 2'b00, 6'b010010, 0, 2'b00};
      rv[14] = '{262, 1, 0, 0, 2'b00, 6'b010010, 1, 2'b00};
      rv[15] = '{263, 1, 0, 0, 2'b00, 6'b010010, 0, 2'b11};

      // Power-up with lock already present
      release_reset();
      #1;
      check("rst_rate", 32'(tx_rate), 32'(6'b001001));
      check("rst_misc", 32'({rc_on, rate_ack, tmo}), 32'(3'b100));
      for (int i = 0; i < 17; i++) begin
         go_to(pv[i].cyc);
         lane_en = pv[i].en;
         #1;
         check($sformatf("pwr@%0d", pv[i].cyc),
               32'({pd_clk, pma, pd_piso, pd_drv, pcs, lane_sync, done}),
               32'({pv[i].clkp, pv[i].pma, pv[i].piso, pv[i].drv, pv[i].pcs,
                    pv[i].sync, pv[i].done}));
      end
      lane_en = 2'b11;

      // Lock loss in DONE, then lock-wait timeout and recovery
      go_to(460);
      pll_lock = 1'b0;
      go_to(462);
      check("lockloss_d2", 32'(done), 32'd1);
      go_to(463);
      check("lockloss_d3", 32'({done, pma, pd_clk}), 32'({1'b0, 2'b11, 2'b00}));
      le = 463;
      go_to(le + 100);
      check("lrst_pma", 32'({pma, pd_clk}), 32'({2'b00, 2'b00}));
      w = le + 320;
      go_to(w + 99);
      check("tmo_before", 32'(tmo), 32'd0);
      go_to(w + 100);
      check("tmo_set", 32'(tmo), 32'd1);
      go_to(w + 110);
      pll_lock = 1'b1;
      go_to(w + 244);
      check("relock_d0", 32'(done), 32'd0);
      go_to(w + 245);
      check("relock_d1", 32'({done, tmo}), 32'(2'b11));

      // Rate change, request held high across the acknowledge
      go_to(w + 250);
      rate_req = 1'b1;
      txckdiv  = 3'd2;
      e = w + 251;
      go_to(e);
      txckdiv = 3'd5;
      for (int i = 0; i < 16; i++) begin
         go_to(e + rv[i].off);
         check($sformatf("rate@+%0d", rv[i].off),
               32'({rc_on, rate_ack, lane_sync, pma, tx_rate, done, pcs}),
               32'({rv[i].rc, rv[i].ack, rv[i].sync, rv[i].pma, rv[i].rate,
                    rv[i].done, rv[i].pcs}));
      end
      rate_req = 1'b0;

      // Second change captures 5; soft reset part-way through it
      e2 = e + 263;
      go_to(e2 + 70);
      check("rate2_applied", 32'({tx_rate, tmo}), 32'({6'b101101, 1'b1}));
      go_to(e2 + 100);
      txlane_rst_n = 1'b0;
      s = e2 + 100;
      go_to(s + 1);
      check("srst_enter", 32'({tmo, done, pma, rc_on, lane_sync}),
            32'({1'b0, 1'b0, 2'b11, 1'b1, 1'b0}));
      go_to(s + 5);
      check("srst_hold", 32'({pma, pd_piso, pd_drv, pcs}), 32'(8'hFF));
      txlane_rst_n = 1'b1;
      go_to(s + 104);
      check("srst_pma_hi", 32'(pma), 32'(2'b11));
      go_to(s + 105);
      check("srst_pma_lo", 32'({pma, pd_clk}), 32'(4'b0000));
      go_to(s + 457);
      check("srst_d0", 32'(done), 32'd0);
      go_to(s + 458);
      check("srst_done", 32'({done, tx_rate, tmo, pcs}), 32'({1'b1, 6'b101101, 1'b0, 2'b00}));

      // Lane 1 disabled for the whole power-up
      lane_en = 2'b01;
      release_reset();
      for (int c = 1; c <= 454; c++) begin
         go_to(c);
         check("lane1_masked", 32'({pd_clk[1], pd_piso[1], pd_drv[1], pma[1], pcs[1]}),
               32'(5'b11111));
      end
      check("lane0_done", 32'({pd_clk, pd_piso, pd_drv, pma, pcs, done, tx_rate}),
            32'({10'b10_10_10_10_10, 1'b1, 6'b001001}));

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
